mem_port_arbiter: RTL and testbench

- Shares one single-ported memory/peripheral bus between the instruction-fetch requester (IF) and the load/store requester (D) of the pipelined core.
- Sits between the datapath and the unified memory, replacing the separate instruction and data ports.
- Fixed-latency reads with one outstanding transaction.
- Data requests win by default; a starvation counter guarantees fetch progress.

---
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory bus between instruction fetch (IF) and load/store (D).
// Data wins by default; a starvation counter forces IF through after STARVE_MAX D grants.
module mem_port_arbiter #(
  parameter int unsigned READ_LAT   = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_wen,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_mask,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_valid,
  output logic        m_wen,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [1:0]  m_mask,
  input  logic [31:0] m_rdata
);

  localparam int unsigned LAT_W  = 3;
  localparam int unsigned STV_W  = 4;
  localparam logic [1:0]  MASK_WORD = 2'b10;
  localparam logic        OWNER_IF  = 1'b0;
  localparam logic        OWNER_D   = 1'b1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [LAT_W-1:0]   lat_cnt, lat_nxt;
  logic               owner, owner_nxt;
  logic [STV_W-1:0]   starve_cnt, starve_nxt;

  logic ret_cycle;
  logic can_grant;
  logic if_win;
  logic d_win;
  logic rd_grant;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      lat_cnt    <= '0;
      owner      <= OWNER_IF;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      lat_cnt    <= lat_nxt;
      owner      <= owner_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // Arbitration and next-state
  always_comb begin
    state_nxt  = state;
    lat_nxt    = lat_cnt;
    owner_nxt  = owner;
    starve_nxt = starve_cnt;

    ret_cycle = (state == S_WAIT) && (lat_cnt == LAT_W'(1));
    can_grant = (state == S_IDLE) || ret_cycle;
    if_win    = can_grant && if_req && (!d_req || (starve_cnt == STV_W'(STARVE_MAX)));
    d_win     = can_grant && d_req && !if_win;
    rd_grant  = if_win || (d_win && !d_wen);

    if (rd_grant) begin
      state_nxt = S_WAIT;
      lat_nxt   = LAT_W'(READ_LAT);
      owner_nxt = d_win ? OWNER_D : OWNER_IF;
    end else if (ret_cycle) begin
      state_nxt = S_IDLE;
      lat_nxt   = '0;
    end else if (state == S_WAIT) begin
      lat_nxt   = lat_cnt - LAT_W'(1);
    end

    // Fairness counter only tracks D grants taken while a fetch is waiting
    if (!if_req || if_win) begin
      starve_nxt = '0;
    end else if (d_win && (starve_cnt != STV_W'(STARVE_MAX))) begin
      starve_nxt = starve_cnt + STV_W'(1);
    end
  end

  // Bus and response outputs; held at zero while reset is asserted
  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    if_rdata  = '0;
    d_rdata   = '0;
    m_valid   = 1'b0;
    m_wen     = 1'b0;
    m_addr    = '0;
    m_wdata   = '0;
    m_mask    = '0;

    if (rst) begin
      if_gnt = if_win;
      d_gnt  = d_win;

      if (if_win) begin
        m_valid = 1'b1;
        m_addr  = if_addr;
        m_mask  = MASK_WORD;
      end else if (d_win) begin
        m_valid = 1'b1;
        m_wen   = d_wen;
        m_addr  = d_addr;
        m_wdata = d_wdata;
        m_mask  = d_mask;
      end

      if (ret_cycle) begin
        if (owner == OWNER_D) begin
          d_rvalid = 1'b1;
          d_rdata  = m_rdata;
        end else begin
          if_rvalid = 1'b1;
          if_rdata  = m_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: dut_a runs READ_LAT=1, dut_b runs READ_LAT=3.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_wen;
  logic [31:0] if_addr, d_addr, d_wdata, m_rdata;
  logic [1:0]  d_mask;

  logic        a_if_gnt, a_if_rvalid, a_d_gnt, a_d_rvalid, a_m_valid, a_m_wen;
  logic [31:0] a_if_rdata, a_d_rdata, a_m_addr, a_m_wdata;
  logic [1:0]  a_m_mask;
  logic        b_if_gnt, b_if_rvalid, b_d_gnt, b_d_rvalid, b_m_valid, b_m_wen;
  logic [31:0] b_if_rdata, b_d_rdata, b_m_addr, b_m_wdata;
  logic [1:0]  b_m_mask;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.READ_LAT(1), .STARVE_MAX(4)) dut_a (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(a_if_gnt),
    .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
    .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata), .d_mask(d_mask),
    .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
    .m_valid(a_m_valid), .m_wen(a_m_wen), .m_addr(a_m_addr), .m_wdata(a_m_wdata),
    .m_mask(a_m_mask), .m_rdata(m_rdata)
  );

  mem_port_arbiter #(.READ_LAT(3), .STARVE_MAX(4)) dut_b (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(b_if_gnt),
    .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata), .d_mask(d_mask),
    .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
    .m_valid(b_m_valid), .m_wen(b_m_wen), .m_addr(b_m_addr), .m_wdata(b_m_wdata),
    .m_mask(b_m_mask), .m_rdata(m_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus at the falling edge; outputs settle 1 time unit later
  task automatic step(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                      input logic [31:0] da, input logic [31:0] dd, input logic [31:0] mr);
    @(negedge clk);
    if_req  = ir;
    if_addr = ia;
    d_req   = dr;
    d_wen   = dw;
    d_addr  = da;
    d_wdata = dd;
    d_mask  = 2'b10;
    m_rdata = mr;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    string pat;
    logic  prev_d;
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_wen = 1'b0;
    d_addr = '0; d_wdata = '0; d_mask = '0; m_rdata = '0;

    // Reset with both requesting: everything quiet
    @(negedge clk);
    rst = 1'b0; if_req = 1'b1; d_req = 1'b1; d_addr = 32'h1234; if_addr = 32'h5678;
    #1;
    chk("rst_if_gnt", 32'(a_if_gnt), 32'd0);
    chk("rst_d_gnt", 32'(a_d_gnt), 32'd0);
    chk("rst_m_valid", 32'(a_m_valid), 32'd0);
    chk("rst_m_addr", a_m_addr, 32'd0);

    // First fetch after release
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    chk("fetch_gnt", 32'(a_if_gnt), 32'd1);
    chk("fetch_maddr", a_m_addr, 32'h8000_0000);
    chk("fetch_mmask", 32'(a_m_mask), 32'd2);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hCAFE_0001);
    chk("fetch_rvalid", 32'(a_if_rvalid), 32'd1);
    chk("fetch_rdata", a_if_rdata, 32'hCAFE_0001);
    chk("fetch_d_rdata0", a_d_rdata, 32'd0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hCAFE_0002);
    chk("idle_rvalid", 32'(a_if_rvalid), 32'd0);
    chk("idle_rdata", a_if_rdata, 32'd0);

    // Both requesting every cycle: D,D,D,D,IF repeating
    pat = "DDDDIDDDDI";
    prev_d = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 32'h0, 32'h100 + 32'(i));
      chk($sformatf("starve_dgnt_%0d", i), 32'(a_d_gnt), 32'(pat[i] == "D"));
      chk($sformatf("starve_ignt_%0d", i), 32'(a_if_gnt), 32'(pat[i] == "I"));
      if (i > 0) begin
        chk($sformatf("starve_drv_%0d", i), 32'(a_d_rvalid), 32'(prev_d));
        chk($sformatf("starve_irv_%0d", i), 32'(a_if_rvalid), 32'(!prev_d));
      end
      prev_d = (pat[i] == "D");
    end
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_0ABC);
    chk("starve_last_irv", 32'(a_if_rvalid), 32'd1);
    chk("starve_last_irdata", a_if_rdata, 32'h0000_0ABC);

    // Store completes at grant; waiting fetch goes next cycle
    step(1'b1, 32'h40, 1'b1, 1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 32'h0);
    chk("st_dgnt", 32'(a_d_gnt), 32'd1);
    chk("st_ignt", 32'(a_if_gnt), 32'd0);
    chk("st_mvalid", 32'(a_m_valid), 32'd1);
    chk("st_mwen", 32'(a_m_wen), 32'd1);
    chk("st_maddr", a_m_addr, 32'h8000_1000);
    chk("st_mwdata", a_m_wdata, 32'hDEAD_BEEF);
    step(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    chk("st_next_ignt", 32'(a_if_gnt), 32'd1);
    chk("st_no_drv", 32'(a_d_rvalid), 32'd0);
    chk("st_if_mwen", 32'(a_m_wen), 32'd0);
    chk("st_if_mwdata", a_m_wdata, 32'd0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h7777_0000);
    chk("st_if_rv", 32'(a_if_rvalid), 32'd1);
    chk("st_no_drv2", 32'(a_d_rvalid), 32'd0);

    // READ_LAT=3: return and new grant in the same cycle
    do_reset();
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h2000, 32'h0, 32'h0);
    chk("l3_dgnt", 32'(b_d_gnt), 32'd1);
    chk("l3_mwen", 32'(b_m_wen), 32'd0);
    step(1'b1, 32'h3000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    chk("l3_c1_ignt", 32'(b_if_gnt), 32'd0);
    chk("l3_c1_mvalid", 32'(b_m_valid), 32'd0);
    chk("l3_c1_drv", 32'(b_d_rvalid), 32'd0);
    step(1'b1, 32'h3000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    chk("l3_c2_ignt", 32'(b_if_gnt), 32'd0);
    step(1'b1, 32'h3000, 1'b0, 1'b0, 32'h0, 32'h0, 32'hD00D_0003);
    chk("l3_c3_drv", 32'(b_d_rvalid), 32'd1);
    chk("l3_c3_drdata", b_d_rdata, 32'hD00D_0003);
    chk("l3_c3_ignt", 32'(b_if_gnt), 32'd1);
    chk("l3_c3_maddr", b_m_addr, 32'h3000);
    chk("l3_c3_irdata", b_if_rdata, 32'd0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h1);
    chk("l3_c4_irv", 32'(b_if_rvalid), 32'd0);
    chk("l3_c4_drdata", b_d_rdata, 32'd0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h2);
    chk("l3_c5_irv", 32'(b_if_rvalid), 32'd0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h1F00_0006);
    chk("l3_c6_irv", 32'(b_if_rvalid), 32'd1);
    chk("l3_c6_irdata", b_if_rdata, 32'h1F00_0006);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h3);
    chk("l3_c7_irv", 32'(b_if_rvalid), 32'd0);

    // Reset in the middle of a READ_LAT=3 read drops the read
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h4000, 32'h0, 32'h0);
    chk("rr_dgnt", 32'(b_d_gnt), 32'd1);
    @(negedge clk);
    rst = 1'b0; d_req = 1'b0; if_req = 1'b1; if_addr = 32'h5000;
    #1;
    chk("rr_ignt0", 32'(b_if_gnt), 32'd0);
    chk("rr_mvalid0", 32'(b_m_valid), 32'd0);
    chk("rr_maddr0", b_m_addr, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rr_first_ignt", 32'(b_if_gnt), 32'd1);
    chk("rr_first_maddr", b_m_addr, 32'h5000);
    chk("rr_no_drv_c2", 32'(b_d_rvalid), 32'd0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hAA);
    chk("rr_no_drv_c3", 32'(b_d_rvalid), 32'd0);
    chk("rr_no_irv_c3", 32'(b_if_rvalid), 32'd0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hBB);
    chk("rr_no_drv_c4", 32'(b_d_rvalid), 32'd0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hCC);
    chk("rr_irv_c5", 32'(b_if_rvalid), 32'd1);
    chk("rr_no_drv_c5", 32'(b_d_rvalid), 32'd0);

    // A one-cycle fetch gap clears the starvation count
    do_reset();
    pat = "DDDDDDDDI";
    for (int i = 0; i < 9; i++) begin
      step(i != 3, 32'h600, 1'b1, 1'b0, 32'h700, 32'h0, 32'h0);
      chk($sformatf("gap_dgnt_%0d", i), 32'(a_d_gnt), 32'(pat[i] == "D"));
      chk($sformatf("gap_ignt_%0d", i), 32'(a_if_gnt), 32'(pat[i] == "I"));
    end
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
